// File: rtl/wave_meter.sv
// wave_meter: hysteresis crossing detector that measures period, peak and trough of an 8-bit sample stream.
// Optional feature: define WAVE_METER_AVG_EN to report PERIOD as the mean of the last 4 measured periods.
module wave_meter #(
  parameter int MID  = 128,
  parameter int HYST = 8,
  parameter int PW   = 24
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    DAT,
  output logic [PW-1:0] PERIOD,
  output logic [7:0]    PEAK,
  output logic [7:0]    TROUGH,
  output logic          VALID,
  output logic          LOCK,
  output logic [1:0]    dbg_state
);

  localparam logic [7:0]    TH_HI   = 8'(MID + HYST);
  localparam logic [7:0]    TH_LO   = 8'(MID - HYST);
  localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    d_q, d_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [7:0]    run_max_q, run_max_d;
  logic [7:0]    run_min_q, run_min_d;
  logic [PW-1:0] period_q, period_d;
  logic [7:0]    peak_q, peak_d;
  logic [7:0]    trough_q, trough_d;
  logic          valid_q, valid_d;

  logic          rise;
  logic          timeout;
  logic          first_ev;
  logic          meas_ev;
  logic [PW-1:0] new_period;

`ifdef WAVE_METER_AVG_EN
  localparam int SW = PW + 2;
  logic [3:0][PW-1:0] hist_q, hist_d;
  logic [2:0]         hist_n_q, hist_n_d;
  logic [SW-1:0]      sum_q, sum_d;
`endif

  // Event and timeout decode. A rising event always beats a timeout in the same cycle.
  always_comb begin
    d_d        = DAT;
    rise       = (state_q == ST_LOW) && (d_q >= TH_HI);
    timeout    = lock_q && !rise && (cnt_q == CNT_MAX - PW'(1));
    first_ev   = rise && !lock_q;
    meas_ev    = rise && lock_q;
    new_period = cnt_q + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK: if (d_q <= TH_LO) state_d = ST_LOW;
      ST_LOW:  if (d_q >= TH_HI) state_d = ST_HIGH;
      ST_HIGH: if (d_q <= TH_LO) state_d = ST_LOW;
      default: state_d = ST_SEEK;
    endcase
    if (timeout) state_d = ST_SEEK;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + PW'(1);
    end

    lock_d = lock_q;
    if (rise) begin
      lock_d = 1'b1;
    end else if (timeout) begin
      lock_d = 1'b0;
    end

    // Running extremes restart from the event sample so the window is [event, next event).
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    if (rise) begin
      run_max_d = d_q;
      run_min_d = d_q;
    end else begin
      if (d_q > run_max_q) run_max_d = d_q;
      if (d_q < run_min_q) run_min_d = d_q;
    end
  end

`ifdef WAVE_METER_AVG_EN
  always_comb begin
    period_d = period_q;
    peak_d   = peak_q;
    trough_d = trough_q;
    valid_d  = 1'b0;
    hist_d   = hist_q;
    hist_n_d = hist_n_q;
    sum_d    = sum_q;
    if (first_ev || timeout) begin
      hist_d   = '0;
      hist_n_d = '0;
      sum_d    = '0;
    end else if (meas_ev) begin
      sum_d  = sum_q + SW'(new_period) - SW'(hist_q[3]);
      hist_d = {hist_q[2:0], new_period};
      if (hist_n_q != 3'd4) hist_n_d = hist_n_q + 3'd1;
      // Report only once the 4-entry window holds real measurements.
      if (hist_n_q >= 3'd3) begin
        valid_d  = 1'b1;
        period_d = sum_d[PW+1:2];
        peak_d   = run_max_q;
        trough_d = run_min_q;
      end
    end
  end
`else
  always_comb begin
    period_d = period_q;
    peak_d   = peak_q;
    trough_d = trough_q;
    valid_d  = 1'b0;
    if (meas_ev) begin
      valid_d  = 1'b1;
      period_d = new_period;
      peak_d   = run_max_q;
      trough_d = run_min_q;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_SEEK;
      d_q       <= 8'd128;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      run_max_q <= 8'd0;
      run_min_q <= 8'd255;
      period_q  <= '0;
      peak_q    <= 8'd0;
      trough_q  <= 8'd255;
      valid_q   <= 1'b0;
`ifdef WAVE_METER_AVG_EN
      hist_q    <= '0;
      hist_n_q  <= '0;
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      period_q  <= period_d;
      peak_q    <= peak_d;
      trough_q  <= trough_d;
      valid_q   <= valid_d;
`ifdef WAVE_METER_AVG_EN
      hist_q    <= hist_d;
      hist_n_q  <= hist_n_d;
      sum_q     <= sum_d;
`endif
    end
  end

  // VALID is a single-cycle qualifier: PERIOD/PEAK/TROUGH are new in the cycle it is high and hold otherwise.
  assign PERIOD    = period_q;
  assign PEAK      = peak_q;
  assign TROUGH    = trough_q;
  assign VALID     = valid_q;
  assign LOCK      = lock_q;
  assign dbg_state = state_q;

endmodule
